task_dispatcher: RTL and testbench

Feeds the interleaved endgame solver pipeline with root positions and collects its scores. Host tasks (player/opponent bitboards plus a tag) are queued and issued into whichever solver slot is reloading, and a per-slot tag table is kept. Each finished slot's score is returned to the host, tagged, through a result queue. The block sits directly upstream and downstream of the solver: it drives the solver's enable and root-board inputs and consumes its solved/score outputs.

---
 rtl/task_dispatcher_if.sv | 48 ++++
 rtl/task_dispatcher.sv | 136 +++++++++++++
 tb/tb_task_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/task_dispatcher_if.sv
// Host and solver signal bundle for task_dispatcher.
// slave = dispatcher side, master = host/solver side.
interface task_dispatcher_if #(
    parameter int TAG_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_player;
    logic [63:0]       in_opponent;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic signed [7:0] out_res;

    logic              sv_enable;
    logic [63:0]       sv_player;
    logic [63:0]       sv_opponent;
    logic [2:0]        sv_slot;
    logic              sv_load;
    logic              sv_solved;
    logic signed [7:0] sv_res;

    logic              busy;

    // Valid/ready: a transfer happens on the edge where both are high;
    // the sender holds its payload stable while valid && !ready.
    modport slave (
        input  in_valid, in_player, in_opponent, in_tag,
        output in_ready,
        output out_valid, out_tag, out_res,
        input  out_ready,
        output sv_enable, sv_player, sv_opponent,
        input  sv_slot, sv_load, sv_solved, sv_res,
        output busy
    );

    modport master (
        output in_valid, in_player, in_opponent, in_tag,
        input  in_ready,
        input  out_valid, out_tag, out_res,
        output out_ready,
        input  sv_enable, sv_player, sv_opponent,
        output sv_slot, sv_load, sv_solved, sv_res,
        input  busy
    );
endinterface

// File: rtl/task_dispatcher.sv
// Queues host root positions into reloading solver slots and returns
// tagged scores in completion order through a result queue.
module task_dispatcher #(
    parameter int TAG_W  = 8,
    parameter int DEPTH  = 8,
    parameter int NSLOT  = 7,
    parameter int RDEPTH = 8
) (
    input  logic                iCLOCK,
    input  logic                iRESET,
    task_dispatcher_if.slave    bus,
    output logic                dbg_state
);
    localparam int TAW = $clog2(DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RAW = $clog2(RDEPTH);
    localparam int RCW = RAW + 1;
    localparam int SW  = RAW + 2;
    localparam logic [3:0] NSLOT_L = 4'(NSLOT);

    typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_t;
    state_t state_q, state_d;

    logic [63:0]      tq_player   [DEPTH];
    logic [63:0]      tq_opponent [DEPTH];
    logic [TAG_W-1:0] tq_tag      [DEPTH];
    logic [TAW-1:0]   tq_wr, tq_rd;
    logic [TCW-1:0]   tq_count, tq_count_next;
    logic             in_ready_q;

    // Slot table sized to the full 3-bit slot id; ids >= NSLOT never activate.
    logic [7:0]       active;
    logic [TAG_W-1:0] slot_tag [8];

    logic [TAG_W-1:0] rq_tag [RDEPTH];
    logic [7:0]       rq_res [RDEPTH];
    logic [RAW-1:0]   rq_wr, rq_rd;
    logic [RCW-1:0]   rq_count;

    logic             slot_ok, comp, issue, tpush, tpop, rpop;
    logic [3:0]       inflight;
    logic [SW-1:0]    infl_after, rc_after;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < 8; i++) inflight = inflight + 4'(active[i]);
    end

    assign slot_ok    = {1'b0, bus.sv_slot} < NSLOT_L;
    assign comp       = bus.sv_solved && slot_ok && active[bus.sv_slot];
    assign infl_after = SW'(inflight) - SW'(comp);
    assign rc_after   = SW'(rq_count) + SW'(comp);
    // Reserving a result-queue entry per in-flight task keeps the solver unstalled.
    assign issue      = bus.sv_load && slot_ok && (tq_count != '0)
                        && ((infl_after + rc_after) < SW'(RDEPTH));

    assign tpush = bus.in_valid && in_ready_q;
    assign tpop  = issue;
    assign rpop  = (rq_count != '0) && bus.out_ready;
    assign tq_count_next = tq_count + TCW'(tpush) - TCW'(tpop);

    assign bus.in_ready    = in_ready_q;
    assign bus.sv_player   = issue ? tq_player[tq_rd]   : 64'd0;
    assign bus.sv_opponent = issue ? tq_opponent[tq_rd] : 64'd0;
    assign bus.out_valid   = (rq_count != '0);
    assign bus.out_tag     = (rq_count != '0) ? rq_tag[rq_rd] : '0;
    assign bus.out_res     = (rq_count != '0) ? rq_res[rq_rd] : '0;
    assign bus.busy        = (tq_count != '0) || (inflight != '0) || (rq_count != '0);
    assign dbg_state       = state_q;

    always_ff @(posedge iCLOCK) begin
        if (iRESET) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.sv_enable = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   bus.sv_enable = 1'b1;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            tq_wr      <= '0;
            tq_rd      <= '0;
            tq_count   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (tpush) tq_wr <= tq_wr + 1'b1;
            if (tpop)  tq_rd <= tq_rd + 1'b1;
            tq_count   <= tq_count_next;
            in_ready_q <= tq_count_next < TCW'(DEPTH);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (tpush) begin
            tq_player[tq_wr]   <= bus.in_player;
            tq_opponent[tq_wr] <= bus.in_opponent;
            tq_tag[tq_wr]      <= bus.in_tag;
        end
    end

    // Issue after completion on the same slot: the new task wins the entry.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            active <= '0;
        end else begin
            if (comp) active[bus.sv_slot] <= 1'b0;
            if (issue) begin
                active[bus.sv_slot]   <= 1'b1;
                slot_tag[bus.sv_slot] <= tq_tag[tq_rd];
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rq_wr    <= '0;
            rq_rd    <= '0;
            rq_count <= '0;
        end else begin
            if (comp) begin
                rq_tag[rq_wr] <= slot_tag[bus.sv_slot];
                rq_res[rq_wr] <= bus.sv_res;
                rq_wr         <= rq_wr + 1'b1;
            end
            if (rpop) rq_rd <= rq_rd + 1'b1;
            rq_count <= rq_count + RCW'(comp) - RCW'(rpop);
        end
    end
endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: vector tables plus hand-written
// multi-cycle sequences, with a result scoreboard fed in completion order.
module tb_task_dispatcher;
    localparam int TAG_W = 8;

    logic iCLOCK = 1'b0;
    logic iRESET = 1'b1;
    logic dbg_state;

    task_dispatcher_if #(.TAG_W(TAG_W)) bus();

    task_dispatcher #(.TAG_W(TAG_W), .DEPTH(8), .NSLOT(7), .RDEPTH(8)) dut (
        .iCLOCK    (iCLOCK),
        .iRESET    (iRESET),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [63:0] player;
        logic [63:0] opponent;
        logic [7:0]  tag;
        logic [2:0]  slot;
    } issue_vec_t;

    typedef struct {
        logic [2:0]        slot;
        logic signed [7:0] res;
        logic [7:0]        exp_tag;
        logic signed [7:0] exp_res;
    } comp_vec_t;

    issue_vec_t iv [7];
    comp_vec_t  cv [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // Result scoreboard: every accepted result must match the oldest expectation.
    always @(negedge iCLOCK) begin : mon
        logic [15:0] e;
        if (!iRESET && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got tag 0x%0h res %0d, expected none",
                         bus.out_tag, bus.out_res);
            end else begin
                e = exp_q.pop_front();
                check("result", {48'd0, bus.out_tag, bus.out_res}, {48'd0, e});
            end
        end
    end

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_player   = '0;
        bus.in_opponent = '0;
        bus.in_tag      = '0;
        bus.sv_load     = 1'b0;
        bus.sv_solved   = 1'b0;
        bus.sv_slot     = '0;
        bus.sv_res      = '0;
    endtask

    task automatic apply_reset();
        iRESET = 1'b1;
        drive_idle();
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_sv_enable", 64'(bus.sv_enable), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_res", 64'(bus.out_res), 64'd0);
        iRESET = 1'b0;
        exp_q.delete();
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_sv_enable", 64'(bus.sv_enable), 64'd1);
    endtask

    task automatic push_task(input logic [63:0] p, input logic [63:0] o, input logic [7:0] t);
        int k;
        bus.in_valid    = 1'b1;
        bus.in_player   = p;
        bus.in_opponent = o;
        bus.in_tag      = t;
        k = 0;
        #1;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) check("push_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic sv_cycle(input bit load, input bit solved, input logic [2:0] slot,
                            input logic [7:0] res, input logic [63:0] exp_p,
                            input logic [63:0] exp_o, input string name);
        bus.sv_load   = load;
        bus.sv_solved = solved;
        bus.sv_slot   = slot;
        bus.sv_res    = res;
        #1;
        if (load) begin
            check({name, "_player"}, bus.sv_player, exp_p);
            check({name, "_opponent"}, bus.sv_opponent, exp_o);
        end
        tick();
        bus.sv_load   = 1'b0;
        bus.sv_solved = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 7; i++) begin
            iv[i].player   = 64'h0000_0001_0000_0000 << i;
            iv[i].opponent = 64'h0000_0000_0000_0100 << i;
            iv[i].tag      = 8'(i + 1);
            iv[i].slot     = 3'(i);
        end
        cv[0] = '{3'd6, 8'sd3,  8'd7, 8'sd3};
        cv[1] = '{3'd5, 8'sd2,  8'd6, 8'sd2};
        cv[2] = '{3'd4, 8'sd1,  8'd5, 8'sd1};
        cv[3] = '{3'd3, 8'sd0,  8'd4, 8'sd0};
        cv[4] = '{3'd2, -8'sd1, 8'd3, -8'sd1};
        cv[5] = '{3'd1, -8'sd2, 8'd2, -8'sd2};
        cv[6] = '{3'd0, -8'sd3, 8'd1, -8'sd3};

        bus.out_ready = 1'b1;
        drive_idle();

        // Single task through slot 2, then same-slot completion plus reissue.
        apply_reset();
        push_task(64'h0000_0008_1000_0000, 64'h0000_0010_0800_0000, 8'h5A);
        sv_cycle(1, 0, 3'd2, 8'd0, 64'h0000_0008_1000_0000, 64'h0000_0010_0800_0000, "single_issue");
        repeat (19) tick();
        check("single_busy_inflight", 64'(bus.busy), 64'd1);
        exp_q.push_back(16'h5A04);
        sv_cycle(0, 1, 3'd2, 8'sd4, 64'd0, 64'd0, "single_done");
        check("single_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        tick();
        check("single_busy_end", 64'(bus.busy), 64'd0);
        check("single_drained", 64'(exp_q.size()), 64'd0);

        push_task(64'hAA, 64'hBB, 8'h21);
        sv_cycle(1, 0, 3'd3, 8'd0, 64'hAA, 64'hBB, "same_issue_a");
        push_task(64'hCC, 64'hDD, 8'h22);
        exp_q.push_back({8'h21, 8'sd7});
        sv_cycle(1, 1, 3'd3, 8'sd7, 64'hCC, 64'hDD, "same_swap");
        exp_q.push_back({8'h22, -8'sd2});
        sv_cycle(0, 1, 3'd3, -8'sd2, 64'd0, 64'd0, "same_done_b");
        tick();
        tick();
        check("same_drained", 64'(exp_q.size()), 64'd0);

        // Fill the task queue with no loads.
        apply_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_player   = 64'h1 << i;
            bus.in_opponent = 64'h100 << i;
            bus.in_tag      = 8'(8'h40 + i);
            tick();
        end
        check("fill_in_ready_full", 64'(bus.in_ready), 64'd0);
        bus.in_player   = 64'hDEAD;
        bus.in_opponent = 64'hBEEF;
        tick();
        bus.in_valid = 1'b0;
        check("fill_still_full", 64'(bus.in_ready), 64'd0);
        sv_cycle(1, 0, 3'd0, 8'd0, 64'h1, 64'h100, "fill_issue0");
        check("fill_in_ready_free", 64'(bus.in_ready), 64'd1);
        sv_cycle(1, 0, 3'd1, 8'd0, 64'h2, 64'h200, "fill_issue1");

        // Interleave: issue in slot order, finish in reverse.
        apply_reset();
        for (int i = 0; i < 7; i++) push_task(iv[i].player, iv[i].opponent, iv[i].tag);
        for (int i = 0; i < 7; i++)
            sv_cycle(1, 0, iv[i].slot, 8'd0, iv[i].player, iv[i].opponent, "inter_issue");
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({cv[i].exp_tag, cv[i].exp_res});
            sv_cycle(0, 1, cv[i].slot, cv[i].res, 64'd0, 64'd0, "inter_done");
        end
        tick();
        tick();
        check("inter_drained", 64'(exp_q.size()), 64'd0);
        check("inter_busy_end", 64'(bus.busy), 64'd0);

        // Result backpressure: 8 results held, issue must stop.
        apply_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push_task(64'(i + 1), 64'(i + 17), 8'(8'h10 + i));
        for (int i = 0; i < 7; i++) sv_cycle(1, 0, 3'(i), 8'd0, 64'(i + 1), 64'(i + 17), "bp_issue");
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({8'(8'h10 + i), 8'(i + 10)});
            sv_cycle(0, 1, 3'(i), 8'(i + 10), 64'd0, 64'd0, "bp_done");
        end
        push_task(64'h77, 64'h88, 8'h17);
        sv_cycle(1, 0, 3'd0, 8'd0, 64'h77, 64'h88, "bp_issue8");
        exp_q.push_back({8'h17, 8'd17});
        sv_cycle(0, 1, 3'd0, 8'd17, 64'd0, 64'd0, "bp_done8");
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_head_tag", 64'(bus.out_tag), 64'h10);
        push_task(64'h1818, 64'h2828, 8'h18);
        push_task(64'h1919, 64'h2929, 8'h19);
        sv_cycle(1, 0, 3'd1, 8'd0, 64'd0, 64'd0, "bp_blocked1");
        sv_cycle(1, 0, 3'd2, 8'd0, 64'd0, 64'd0, "bp_blocked2");
        sv_cycle(0, 1, 3'd1, 8'd99, 64'd0, 64'd0, "bp_stray");
        check("bp_head_tag_stable", 64'(bus.out_tag), 64'h10);
        check("bp_head_res_stable", 64'(bus.out_res), 64'd10);
        bus.out_ready = 1'b1;
        repeat (10) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_out_valid_empty", 64'(bus.out_valid), 64'd0);
        sv_cycle(1, 0, 3'd3, 8'd0, 64'h1818, 64'h2828, "bp_resume");
        exp_q.push_back({8'h18, 8'sd5});
        sv_cycle(1, 1, 3'd3, 8'sd5, 64'h1919, 64'h2929, "bp_resume2");
        exp_q.push_back({8'h19, -8'sd6});
        sv_cycle(0, 1, 3'd3, -8'sd6, 64'd0, 64'd0, "bp_resume_done");
        tick();
        tick();
        check("bp_final_drained", 64'(exp_q.size()), 64'd0);
        check("bp_busy_end", 64'(bus.busy), 64'd0);

        // Idle and out-of-range slots.
        apply_reset();
        sv_cycle(0, 1, 3'd4, -8'sd10, 64'd0, 64'd0, "idle_solved");
        check("idle_no_valid", 64'(bus.out_valid), 64'd0);
        sv_cycle(0, 1, 3'd7, 8'sd1, 64'd0, 64'd0, "idle_slot7");
        check("idle_slot7_no_valid", 64'(bus.out_valid), 64'd0);
        push_task(64'h55, 64'h66, 8'h33);
        sv_cycle(1, 0, 3'd7, 8'd0, 64'd0, 64'd0, "slot7_load");
        sv_cycle(1, 0, 3'd5, 8'd0, 64'h55, 64'h66, "slot5_load");
        exp_q.push_back({8'h33, -8'sd64});
        sv_cycle(0, 1, 3'd5, -8'sd64, 64'd0, 64'd0, "slot5_done");
        tick();
        check("idle_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-run with 3 in flight and 2 queued.
        apply_reset();
        for (int i = 0; i < 5; i++) push_task(64'(i + 100), 64'(i + 200), 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) sv_cycle(1, 0, 3'(i), 8'd0, 64'(i + 100), 64'(i + 200), "mid_issue");
        check("mid_busy", 64'(bus.busy), 64'd1);
        iRESET = 1'b1;
        tick();
        check("mid_sv_enable", 64'(bus.sv_enable), 64'd0);
        check("mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_busy_cleared", 64'(bus.busy), 64'd0);
        iRESET = 1'b0;
        tick();
        check("mid_restart_enable", 64'(bus.sv_enable), 64'd1);
        sv_cycle(0, 1, 3'd0, 8'sd3, 64'd0, 64'd0, "mid_stale");
        check("mid_stale_no_valid", 64'(bus.out_valid), 64'd0);
        sv_cycle(1, 0, 3'd1, 8'd0, 64'd0, 64'd0, "mid_empty_load");
        tick();
        check("mid_busy_idle", 64'(bus.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
